// File: rtl/pq_traffic_checker.sv
// Traffic generator and golden-model checker for a min-first priority queue.
// Issues LFSR-keyed enq/deq/replace ops and counts key and empty-flag mismatches.
module pq_traffic_checker #(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned VAL_WIDTH = 8,
  parameter int unsigned PQ_DEPTH  = 15,
  parameter int unsigned NUM_OPS   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [7:0]                     gap,
  output logic                           pq_enq,
  output logic                           pq_deq,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvi,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
  input  logic                           pq_empty,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [15:0]                    err_count,
  output logic [15:0]                    op_count,
  output logic [KEY_WIDTH-1:0]           last_exp,
  output logic [KEY_WIDTH-1:0]           last_got
);
  localparam int unsigned CW = $clog2(PQ_DEPTH + 1);
  localparam int unsigned IW = (PQ_DEPTH > 1) ? $clog2(PQ_DEPTH) : 1;
  localparam logic [15:0]   SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CW-1:0] DEPTH_C   = CW'(PQ_DEPTH);
  localparam logic [15:0]   NUM_OPS_C = 16'(NUM_OPS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {P_FILL, P_MIX, P_DRAIN} phase_t;

  state_t               r_state, w_state_nxt;
  phase_t               r_phase;
  logic                 r_replace;
  logic [7:0]           r_gap;
  logic [7:0]           r_wait_cnt;
  logic [15:0]          r_lfsr;
  logic [CW-1:0]        r_cnt;
  logic [15:0]          r_mix_cnt;
  logic [15:0]          r_op_count;
  logic [15:0]          r_err_count;
  logic [KEY_WIDTH-1:0] r_last_exp;
  logic [KEY_WIDTH-1:0] r_last_got;
  logic [PQ_DEPTH-1:0]  r_vld;
  logic [KEY_WIDTH-1:0] r_key [PQ_DEPTH];

  logic                 w_accept, w_do_enq, w_do_deq, w_key_err, w_empty_err, w_last_wait;
  logic                 w_min_found, w_free_found, w_unused_val;
  logic [KEY_WIDTH-1:0] w_min_key, w_new_key, w_got_key;
  logic [IW-1:0]        w_min_idx, w_free_idx;
  logic [CW-1:0]        w_cnt_inc;
  logic [15:0]          w_lfsr_nxt, w_err_inc;

  assign w_accept     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_new_key    = r_lfsr[KEY_WIDTH-1:0];
  assign w_got_key    = pq_kvo[KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH];
  assign w_unused_val = ^pq_kvo[VAL_WIDTH-1:0];
  assign w_cnt_inc    = r_cnt + CW'(1);
  assign w_lfsr_nxt   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_err_inc    = (r_err_count != '1) ? r_err_count + 16'd1 : r_err_count;
  assign w_last_wait  = (r_state == S_WAIT) && (r_wait_cnt == '0);
  assign w_key_err    = (r_state == S_ISSUE) && w_do_deq && (w_got_key != w_min_key);
  assign w_empty_err  = w_last_wait && (pq_empty != (r_cnt == '0));

  // Shadow scan: lowest-index entry holding the minimum key, and lowest free slot.
  always_comb begin
    w_min_found  = 1'b0;
    w_min_key    = '1;
    w_min_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned i = 0; i < PQ_DEPTH; i++) begin
      if (r_vld[i] && (!w_min_found || r_key[i] < w_min_key)) begin
        w_min_found = 1'b1;
        w_min_key   = r_key[i];
        w_min_idx   = IW'(i);
      end
      if (!r_vld[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_do_enq = 1'b0;
    w_do_deq = 1'b0;
    unique case (r_phase)
      P_FILL:  w_do_enq = 1'b1;
      P_MIX: begin
        if (r_replace) begin
          w_do_enq = 1'b1;
          w_do_deq = 1'b1;
        end else if (r_cnt == '0)      w_do_enq = 1'b1;
        else if (r_cnt == DEPTH_C)     w_do_deq = 1'b1;
        else if (r_lfsr[15])           w_do_enq = 1'b1;
        else                           w_do_deq = 1'b1;
      end
      P_DRAIN: w_do_deq = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    pq_enq      = 1'b0;
    pq_deq      = 1'b0;
    pq_kvi      = '0;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        pq_enq      = w_do_enq;
        pq_deq      = w_do_deq;
        pq_kvi      = {r_lfsr[KEY_WIDTH-1:0], r_op_count[VAL_WIDTH-1:0]};
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (r_wait_cnt == '0)
        w_state_nxt = (r_phase == P_DRAIN && r_cnt == '0) ? S_DONE : S_ISSUE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= P_FILL;
      r_replace   <= 1'b0;
      r_gap       <= 8'd1;
      r_wait_cnt  <= '0;
      r_lfsr      <= SEED;
      r_cnt       <= '0;
      r_mix_cnt   <= '0;
      r_op_count  <= '0;
      r_err_count <= '0;
      r_last_exp  <= '0;
      r_last_got  <= '0;
      r_vld       <= '0;
      r_key       <= '{default: '0};
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_phase     <= (mode == 2'd1) ? P_MIX : P_FILL;
        r_replace   <= (mode == 2'd2);
        r_gap       <= (gap == 8'd0) ? 8'd1 : gap;
        r_cnt       <= '0;
        r_mix_cnt   <= '0;
        r_op_count  <= '0;
        r_err_count <= '0;
        r_last_exp  <= '0;
        r_last_got  <= '0;
        r_vld       <= '0;
      end else if (r_state == S_ISSUE) begin
        r_lfsr     <= w_lfsr_nxt;
        r_wait_cnt <= r_gap - 8'd1;
        if (r_op_count != '1) r_op_count <= r_op_count + 16'd1;
        if (w_key_err) begin
          r_err_count <= w_err_inc;
          r_last_exp  <= w_min_key;
          r_last_got  <= w_got_key;
        end
        // Replace reuses the min slot, so occupancy stays unchanged.
        if (w_do_enq && w_do_deq) begin
          r_key[w_min_idx] <= w_new_key;
        end else if (w_do_enq) begin
          r_key[w_free_idx] <= w_new_key;
          r_vld[w_free_idx] <= 1'b1;
          r_cnt             <= w_cnt_inc;
        end else if (w_do_deq) begin
          r_vld[w_min_idx] <= 1'b0;
          r_cnt            <= r_cnt - CW'(1);
        end
        unique case (r_phase)
          P_FILL: if (w_cnt_inc == DEPTH_C) begin
            r_phase   <= r_replace ? P_MIX : P_DRAIN;
            r_mix_cnt <= '0;
          end
          P_MIX: begin
            r_mix_cnt <= r_mix_cnt + 16'd1;
            if (r_mix_cnt + 16'd1 == NUM_OPS_C) r_phase <= P_DRAIN;
          end
          default: ;
        endcase
      end else if (r_state == S_WAIT) begin
        if (r_wait_cnt != '0)  r_wait_cnt  <= r_wait_cnt - 8'd1;
        else if (w_empty_err)  r_err_count <= w_err_inc;
      end
    end
  end

  assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err_count == '0);
  assign err_count = r_err_count;
  assign op_count  = r_op_count;
  assign last_exp  = r_last_exp;
  assign last_got  = r_last_got;
endmodule
